soc_bus_arbiter: RTL

//  Round-robin arbiter and transfer sequencer for the shared SoC peripheral bus (timer/LED/RAM decode).

---
 rtl/soc_bus_pkg.sv | 22 ++
 rtl/soc_rr_arbiter.sv | 47 ++++
 rtl/soc_bus_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg
//   Shared definitions for the SoC peripheral bus arbiter:
//   - default address/data widths
//   - sequencer state encoding (IDLE/XFER/DONE)
//   - base addresses of the decoded peripheral regions (upper 16 address bits)
package soc_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Region bases, compared against address bits [31:16] by the slave decoder.
  localparam logic [15:0] TIMER_BASE = 16'h4000;
  localparam logic [15:0] LED_BASE   = 16'h4001;
  localparam logic [15:0] RAM_BASE   = 16'h2000;

endpackage

// File: rtl/soc_rr_arbiter.sv
// soc_rr_arbiter
//   Purely combinational round-robin pick. The search starts at the master
//   just after rr_ptr and wraps, so the previous owner gets lowest priority.
// Ports
//   req     in   NUM_MASTERS  request vector
//   rr_ptr  in   IW           index of the last granted master
//   grant   out  NUM_MASTERS  one-hot winner (all zero when no request)
//   idx     out  IW           binary index of the winner
//   valid   out  1            at least one request present
module soc_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IW          = 1
)(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          rr_ptr,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IW-1:0]          idx,
  output logic                   valid
);

  // cand[k] is the master examined at search step k: rr_ptr+1+k mod N.
  logic [IW-1:0] cand [NUM_MASTERS];
  logic          found;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
      assign cand[gi] = IW'((int'(rr_ptr) + gi + 1) % NUM_MASTERS);
    end
  endgenerate

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found && req[cand[k]]) begin
        found          = 1'b1;
        grant[cand[k]] = 1'b1;
        idx            = cand[k];
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter
//   Round-robin arbiter and single-transfer sequencer for the shared
//   peripheral bus. One master owns the bus at a time; its request is latched
//   onto the slave side, the sequencer waits for s_ready (or a timeout) and
//   returns read data / error with a one-cycle m_done pulse.
// Ports
//   clk, reset          clock, synchronous active-high reset
//   m_req/m_we          per-master request and direction (1=write)
//   m_addr/m_wdata      packed per-master address and write data
//   m_grant/m_done      one-hot owner and completion pulse
//   m_rdata/m_err       read data and timeout flag, valid with m_done
//   s_addr/s_wdata      slave address and write data
//   s_we/s_re           slave strobes, held for the whole transfer
//   s_rdata/s_ready     slave read data and completion
//   busy                sequencer not idle
module soc_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT     = 16
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_grant,
  output logic [NUM_MASTERS-1:0]        m_done,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_err,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic                          s_we,
  output logic                          s_re,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_ready,
  output logic                          busy
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state_reg;
  logic [IW-1:0] rr_ptr_reg;
  logic [IW-1:0] owner_reg;
  logic [TW-1:0] tcnt_reg;

  logic [ADDR_W-1:0] addr_arr  [NUM_MASTERS];
  logic [DATA_W-1:0] wdata_arr [NUM_MASTERS];

  logic [NUM_MASTERS-1:0] arb_grant;
  logic [IW-1:0]          arb_idx;
  logic                   arb_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = m_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  soc_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IW          (IW)
  ) u_arb (
    .req    (m_req),
    .rr_ptr (rr_ptr_reg),
    .grant  (arb_grant),
    .idx    (arb_idx),
    .valid  (arb_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= IW'(NUM_MASTERS - 1);  // master 0 wins first
      owner_reg  <= '0;
      tcnt_reg   <= '0;
      m_grant    <= '0;
      m_done     <= '0;
      m_rdata    <= '0;
      m_err      <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      s_we       <= 1'b0;
      s_re       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_valid) begin
            s_addr    <= addr_arr[arb_idx];
            s_wdata   <= wdata_arr[arb_idx];
            s_we      <= m_we[arb_idx];
            s_re      <= ~m_we[arb_idx];
            m_grant   <= arb_grant;
            owner_reg <= arb_idx;
            tcnt_reg  <= '0;
            state_reg <= XFER;
          end
        end
        XFER: begin
          // s_ready has priority over a timeout landing in the same cycle.
          if (s_ready) begin
            if (s_re) m_rdata <= s_rdata;
            m_err     <= 1'b0;
            m_done    <= m_grant;
            s_we      <= 1'b0;
            s_re      <= 1'b0;
            state_reg <= DONE;
          end else if (tcnt_reg == TW'(TIMEOUT - 1)) begin
            m_rdata   <= '0;
            m_err     <= 1'b1;
            m_done    <= m_grant;
            s_we      <= 1'b0;
            s_re      <= 1'b0;
            state_reg <= DONE;
          end else begin
            tcnt_reg <= tcnt_reg + 1'b1;
          end
        end
        DONE: begin
          // No arbitration here: the owner gets a cycle to drop m_req.
          rr_ptr_reg <= owner_reg;
          m_grant    <= '0;
          m_done     <= '0;
          m_err      <= 1'b0;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);

endmodule
